score_evaluation: RTL and testbench
===================================

# score_evaluation

Scoring block of the whack-a-mole game. It compares the player's 3-bit hole guess against the current mole position when an evaluation strobe arrives, and keeps an 8-bit running score. It also presents correct/wrong feedback flags to the display logic. It sits between the button/switch input logic (user_guess, eval_now) and the mole generator (mole_pos, mole_change). Only one guess is scored per mole appearance.

## Interface
Parameters: none.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  reset, asynchronous, active-high
- user_guess  input  3  hole index selected by the player (0-7)
- mole_pos  input  3  hole index where the mole currently is (0-7)
- eval_now  input  1  request to evaluate user_guess; level-sampled each clock
- mole_change  input  1  one-cycle pulse from the mole generator marking a new mole period
- score  output  8  count of correct guesses, saturating at 255
- guess_correct  output  1  level; the accepted guess of the current mole period matched
- guess_wrong  output  1  level; the accepted guess of the current mole period did not match
- guess_now  output  1  one-cycle pulse in the cycle after a guess is accepted

## Operation
- Internal state: score[7:0], locked (guess already taken this period), prev_pos[2:0] (registered mole_pos), guess_correct, guess_wrong, guess_now.
- New mole period detected in a cycle when mole_change==1 OR mole_pos != prev_pos. prev_pos <= mole_pos every cycle.
- On a new-period cycle: locked, guess_correct and guess_wrong are cleared, unless an accept happens in the same cycle (see below).
- Accept condition: eval_now==1 AND (locked==0 OR new-period this cycle).
- On accept: compare user_guess with the current-cycle mole_pos.
  - Equal: score <= score+1, saturating at 8'hFF. guess_correct<=1, guess_wrong<=0.
  - Unequal: score unchanged (no penalty). guess_wrong<=1, guess_correct<=0.
  - In both cases: locked<=1 and guess_now<=1 for exactly one cycle.
- eval_now while locked and no new period: ignored. No score change, flags hold, guess_now stays 0.
- eval_now held high for many cycles counts once per mole period.
- score is never cleared except by rst.

## Timing
- Reset (async, immediate): score=0, guess_correct=0, guess_wrong=0, guess_now=0, locked=0, prev_pos=0.
- First rising edge after rst deasserts may see mole_pos!=0 as a new period. This is harmless because locked is already 0.
- Latency: eval_now sampled high at edge N. score, guess_correct/guess_wrong and guess_now are all valid after edge N (1 cycle).
- guess_now is high for the single cycle following edge N.
- Flags stay valid until the edge at which a new period is detected. They clear after that edge.
- Simultaneous new period and eval_now: new period wins the lock clear, the guess is accepted and judged against the new mole_pos, and the flags reflect that guess.
- Saturation: score==255 with a correct guess keeps 255. The flags and guess_now still update.

## Test plan
- Reset and idle: assert rst; mole_pos steps 0->1->2->3 with no eval_now -> score=0, all flags 0, guess_now never pulses.
- Correct guess: mole_pos=4, user_guess=4, eval_now pulsed 1 cycle -> score 0->1 one cycle later, guess_correct=1, guess_now 1-cycle pulse. Then mole_pos->0 -> guess_correct clears.
- Wrong guess: mole_pos=1, user_guess=2, eval_now pulse -> score stays 1, guess_wrong=1, guess_now pulses.
- Lock release by position change: after the wrong guess, mole_pos->2, then user_guess=2 with eval_now pulse -> score=2, guess_correct=1, guess_wrong=0.
- Lock and hold: eval_now held high 20 cycles with a matching guess -> score +1 only once. A second pulse before mole_change/mole_pos change -> no change. A mole_change pulse with unchanged mole_pos, then eval -> accepted.
- Saturation and async reset: 256+ correct accepted guesses -> score holds 255. Asserting rst mid-period, between clock edges -> score and flags 0 immediately.

Source files
------------

// File: rtl/score_evaluation.sv
// score_evaluation: scores one player guess per mole appearance.
// It keeps a saturating 8-bit count of correct guesses, holds the
// correct/wrong flags for the current mole period, and pulses
// guess_now for one cycle after each accepted guess.
module score_evaluation (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] user_guess,
    input  logic [2:0] mole_pos,
    input  logic       eval_now,
    input  logic       mole_change,
    output logic [7:0] score,
    output logic       guess_correct,
    output logic       guess_wrong,
    output logic       guess_now
);

    // A mole period is either still open for a guess or already scored.
    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    localparam logic [7:0] SCORE_MAX = 8'hFF;

    lock_state_t lock_state;
    lock_state_t lock_state_next;
    logic [2:0]  prev_pos;
    logic        new_period;
    logic        accept;
    logic        hit;

    // A fresh mole period starts on an explicit pulse or on any position change.
    assign new_period = mole_change || (mole_pos != prev_pos);

    // A new period reopens the lock in the same cycle, so a guess arriving
    // together with a new mole is judged against the new position.
    assign accept = eval_now && ((lock_state == UNLOCKED) || new_period);
    assign hit    = (user_guess == mole_pos);

    // Lock state register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: all clocked state uses non-blocking assignments so every
        // register samples values from before the edge.
        if (rst) begin
            lock_state <= UNLOCKED;
        end else begin
            lock_state <= lock_state_next;
        end
    end

    // Next lock state: an accept locks, a new period without an accept unlocks.
    always_comb begin
        // NOTE: default assigned first so no path leaves the signal unassigned
        // and no latch is inferred.
        lock_state_next = lock_state;
        if (accept) begin
            lock_state_next = LOCKED;
        end else if (new_period) begin
            lock_state_next = UNLOCKED;
        end
    end

    // Track the previous mole position for change detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_pos <= 3'd0;
        end else begin
            prev_pos <= mole_pos;
        end
    end

    // Score: counts correct accepted guesses, holds at the maximum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            score <= 8'd0;
        end else if (accept && hit && (score != SCORE_MAX)) begin
            score <= score + 8'd1;
        end
    end

    // Feedback flags: set by an accepted guess, cleared by a new period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            guess_correct <= 1'b0;
            guess_wrong   <= 1'b0;
        end else if (accept) begin
            guess_correct <= hit;
            guess_wrong   <= !hit;
        end else if (new_period) begin
            guess_correct <= 1'b0;
            guess_wrong   <= 1'b0;
        end
    end

    // One-cycle pulse following each accepted guess.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            guess_now <= 1'b0;
        end else begin
            guess_now <= accept;
        end
    end

endmodule

// File: tb/tb_score_evaluation.sv
// Testbench for score_evaluation: directed stimulus, a behavioural
// scoreboard compared every cycle, and hand-computed literal checks.
module tb_score_evaluation;

    logic       clk;
    logic       rst;
    logic [2:0] user_guess;
    logic [2:0] mole_pos;
    logic       eval_now;
    logic       mole_change;
    logic [7:0] score;
    logic       guess_correct;
    logic       guess_wrong;
    logic       guess_now;

    int total = 0;
    int bad   = 0;

    score_evaluation dut (
        .clk           (clk),
        .rst           (rst),
        .user_guess    (user_guess),
        .mole_pos      (mole_pos),
        .eval_now      (eval_now),
        .mole_change   (mole_change),
        .score         (score),
        .guess_correct (guess_correct),
        .guess_wrong   (guess_wrong),
        .guess_now     (guess_now)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Scoreboard: what the game rules say the outputs must be.
    int m_score;
    int m_last_pos;
    bit m_taken;
    int m_verdict;   // 0 = no verdict, 1 = correct, 2 = wrong
    bit m_pulse;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_score    = 0;
            m_last_pos = 0;
            m_taken    = 0;
            m_verdict  = 0;
            m_pulse    = 0;
        end else begin
            bit fresh;
            fresh   = mole_change || (int'(mole_pos) != m_last_pos);
            m_pulse = 0;
            if (eval_now && (!m_taken || fresh)) begin
                m_taken = 1;
                m_pulse = 1;
                if (user_guess == mole_pos) begin
                    m_verdict = 1;
                    if (m_score < 255) m_score = m_score + 1;
                end else begin
                    m_verdict = 2;
                end
            end else if (fresh) begin
                m_taken   = 0;
                m_verdict = 0;
            end
            m_last_pos = int'(mole_pos);
        end
    end

    // Compare DUT against the scoreboard mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            check("score",         int'(score),         m_score);
            check("guess_correct", int'(guess_correct), int'(m_verdict == 1));
            check("guess_wrong",   int'(guess_wrong),   int'(m_verdict == 2));
            check("guess_now",     int'(guess_now),     int'(m_pulse));
        end
    end

    // Advance n rising edges, then move 2ns past the edge to drive/check.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        user_guess  = 3'd0;
        mole_pos    = 3'd0;
        eval_now    = 1'b0;
        mole_change = 1'b0;
        #3;
        check("reset score", int'(score), 0);
        check("reset flags", int'({guess_correct, guess_wrong, guess_now}), 0);
        step(2);
        rst = 1'b0;

        // Idle: mole moves, nobody guesses.
        for (int p = 1; p <= 3; p++) begin
            mole_pos = 3'(p);
            step(1);
            check("idle guess_now", int'(guess_now), 0);
        end
        check("idle score", int'(score), 0);

        // Correct guess.
        mole_pos = 3'd4;
        step(1);
        user_guess = 3'd4;
        eval_now   = 1'b1;
        step(1);
        eval_now = 1'b0;
        check("hit score", int'(score), 1);
        check("hit correct", int'(guess_correct), 1);
        check("hit pulse", int'(guess_now), 1);
        step(1);
        check("hit pulse ends", int'(guess_now), 0);
        check("hit correct holds", int'(guess_correct), 1);
        mole_pos = 3'd0;
        step(1);
        check("hit correct cleared", int'(guess_correct), 0);

        // Wrong guess.
        mole_pos = 3'd1;
        step(1);
        user_guess = 3'd2;
        eval_now   = 1'b1;
        step(1);
        eval_now = 1'b0;
        check("miss score", int'(score), 1);
        check("miss wrong", int'(guess_wrong), 1);
        check("miss pulse", int'(guess_now), 1);
        step(1);

        // Lock released by position change.
        mole_pos = 3'd2;
        step(1);
        check("release wrong cleared", int'(guess_wrong), 0);
        eval_now = 1'b1;
        step(1);
        eval_now = 1'b0;
        check("release score", int'(score), 2);
        check("release correct", int'(guess_correct), 1);
        check("release wrong", int'(guess_wrong), 0);
        step(1);

        // Held eval_now counts once per period.
        mole_pos = 3'd5;
        step(1);
        user_guess = 3'd5;
        eval_now   = 1'b1;
        step(20);
        eval_now = 1'b0;
        check("hold score", int'(score), 3);
        step(1);
        eval_now = 1'b1;
        step(1);
        eval_now = 1'b0;
        check("locked score", int'(score), 3);
        check("locked pulse", int'(guess_now), 0);
        mole_change = 1'b1;
        step(1);
        mole_change = 1'b0;
        check("mole_change clears", int'(guess_correct), 0);
        eval_now = 1'b1;
        step(1);
        eval_now = 1'b0;
        check("after mole_change score", int'(score), 4);

        // New period and guess in the same cycle.
        mole_pos   = 3'd6;
        user_guess = 3'd6;
        eval_now   = 1'b1;
        step(1);
        check("simul hit score", int'(score), 5);
        check("simul hit correct", int'(guess_correct), 1);
        mole_pos = 3'd7;
        step(1);
        eval_now = 1'b0;
        check("simul miss score", int'(score), 5);
        check("simul miss wrong", int'(guess_wrong), 1);
        check("simul miss pulse", int'(guess_now), 1);

        // Saturation: every cycle is a new period with a matching guess.
        eval_now = 1'b1;
        for (int i = 0; i < 260; i++) begin
            mole_pos   = (i % 2 == 0) ? 3'd3 : 3'd4;
            user_guess = mole_pos;
            step(1);
        end
        check("saturated score", int'(score), 255);
        mole_pos   = 3'd1;
        user_guess = 3'd1;
        step(1);
        eval_now = 1'b0;
        check("saturated hold", int'(score), 255);
        check("saturated pulse", int'(guess_now), 1);
        check("saturated correct", int'(guess_correct), 1);

        // Asynchronous reset between edges.
        #1;
        rst = 1'b1;
        #1;
        check("async score", int'(score), 0);
        check("async flags", int'({guess_correct, guess_wrong, guess_now}), 0);
        step(2);
        rst = 1'b0;
        step(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
